// File: rtl/xfer_sched.sv
// Round-robin scheduler sharing one slow-rate word path into a clock-domain crossing.
// Optional XFER_MISS_CNT_EN adds a saturating count of ticks that found no request.
module xfer_sched #(
  parameter int NREQ   = 4,
  parameter int DW     = 5,
  parameter int DIV    = 50_000_000,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data_in,
  output logic [NREQ-1:0]          grant,
  output logic [DW-1:0]            x_data,
  output logic [$clog2(NREQ)-1:0]  x_src,
  output logic                     x_strobe,
  output logic                     busy
`ifdef XFER_MISS_CNT_EN
  ,
  output logic [7:0]               miss_cnt
`endif
);

  localparam int SW  = $clog2(NREQ);
  localparam int CW  = $clog2(DIV);
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (DIV < SETTLE + 4 || SETTLE < 1 || NREQ < 2 || NREQ > 8) begin : g_param_check
    $error("xfer_sched: requires DIV >= SETTLE+4, SETTLE >= 1, 2 <= NREQ <= 8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_STROBE
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    cnt_reg;
  logic [STW-1:0]   settle_reg;
  logic [SW-1:0]    ptr_reg;
  logic [SW-1:0]    winner;
  logic [SW-1:0]    cand;
  logic             found;
  logic             tick;
  logic             load;
  logic [DW-1:0]    words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words[gi] = data_in[gi*DW +: DW];
  end

  assign tick = (cnt_reg == CW'(DIV - 1));

  // Scan from the requester after the last winner so every requester gets a turn.
  always_comb begin
    winner = ptr_reg;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = SW'((int'(ptr_reg) + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    busy       = 1'b0;
    x_strobe   = 1'b0;
    grant      = '0;
    case (state_reg)
      S_IDLE: begin
        if (tick && (|req)) begin
          load       = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_reg == '0) state_next = S_STROBE;
      end
      S_STROBE: begin
        busy          = 1'b1;
        x_strobe      = 1'b1;
        grant[x_src]  = 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      state_reg  <= S_IDLE;
      settle_reg <= '0;
      ptr_reg    <= SW'(NREQ - 1);
      x_data     <= '0;
      x_src      <= '0;
    end else begin
      cnt_reg   <= tick ? '0 : cnt_reg + CW'(1);
      state_reg <= state_next;
      if (load) begin
        x_data     <= words[winner];
        x_src      <= winner;
        ptr_reg    <= winner;
        settle_reg <= STW'(SETTLE - 1);
      end else if (state_reg == S_SETTLE && settle_reg != '0) begin
        settle_reg <= settle_reg - STW'(1);
      end
    end
  end

`ifdef XFER_MISS_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt <= '0;
    end else if (state_reg == S_IDLE && tick && !(|req) && miss_cnt != 8'hFF) begin
      miss_cnt <= miss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xfer_sched.sv
// Scoreboard bench for xfer_sched: a transaction model predicts each strobe at tick time.
module tb_xfer_sched;

  localparam int NREQ   = 4;
  localparam int DW     = 5;
  localparam int DIV    = 8;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] data_in;
  logic [3:0]  grant;
  logic [4:0]  x_data;
  logic [1:0]  x_src;
  logic        x_strobe;
  logic        busy;
`ifdef XFER_MISS_CNT_EN
  logic [7:0]  miss_cnt;
`endif

  xfer_sched #(.NREQ(NREQ), .DW(DW), .DIV(DIV), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .x_data   (x_data),
    .x_src    (x_src),
    .x_strobe (x_strobe),
    .busy     (busy)
`ifdef XFER_MISS_CNT_EN
    ,
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [4:0] data;
    logic [1:0] src;
  } exp_t;

  exp_t sb[$];
  int   log_cyc[$];
  int   log_grant[$];
  int   log_data[$];

  int         checks   = 0;
  int         failures = 0;
  int         gcyc;
  int         ref_cnt;
  int         ref_ptr;
  int         w;
  bit         found;
  exp_t       e;
  logic [4:0] exp_xdata;
  logic [1:0] exp_xsrc;
  bit         exp_st;
  bit         exp_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, gcyc);
    end
  endtask

  // Transaction model: on each tick, pick the winner and schedule its strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      gcyc      = 0;
      ref_cnt   = 0;
      ref_ptr   = NREQ - 1;
      exp_xdata = '0;
      exp_xsrc  = '0;
    end else begin
      if (ref_cnt == DIV - 1 && req != 4'b0000) begin
        w     = ref_ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req[2'((ref_ptr + k) % NREQ)]) begin
            w     = (ref_ptr + k) % NREQ;
            found = 1'b1;
          end
        end
        e.cyc   = gcyc + 1 + SETTLE;
        e.grant = 4'(1 << w);
        e.data  = 5'(data_in >> (w * DW));
        e.src   = 2'(w);
        sb.push_back(e);
        ref_ptr   = w;
        exp_xdata = e.data;
        exp_xsrc  = e.src;
      end
      ref_cnt = (ref_cnt == DIV - 1) ? 0 : ref_cnt + 1;
      gcyc++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_grant",  32'(grant),    32'd0);
      chk("rst_strobe", 32'(x_strobe), 32'd0);
      chk("rst_busy",   32'(busy),     32'd0);
      chk("rst_x_data", 32'(x_data),   32'd0);
      chk("rst_x_src",  32'(x_src),    32'd0);
    end else begin
      exp_st   = (sb.size() > 0) && (sb[0].cyc == gcyc);
      exp_busy = (sb.size() > 0) && (gcyc >= sb[0].cyc - SETTLE);
      chk("x_strobe", 32'(x_strobe), 32'(exp_st));
      chk("busy",     32'(busy),     32'(exp_busy));
      chk("x_data",   32'(x_data),   32'(exp_xdata));
      chk("x_src",    32'(x_src),    32'(exp_xsrc));
      if (exp_st) begin
        chk("grant", 32'(grant), 32'(sb[0].grant));
        void'(sb.pop_front());
      end else begin
        chk("grant_idle", 32'(grant), 32'd0);
      end
      if (x_strobe) begin
        log_cyc.push_back(gcyc);
        log_grant.push_back(int'(grant));
        log_data.push_back(int'(x_data));
        $display("xfer cycle=%0d grant=%b x_src=%0d x_data=%h", gcyc, grant, x_src, x_data);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    run(2);
    log_cyc.delete();
    log_grant.delete();
    log_data.delete();
    reset = 1'b0;
  endtask

  task automatic set_word(input int i, input logic [4:0] v);
    data_in = (data_in & ~(20'h1F << (i * DW))) | (20'(v) << (i * DW));
  endtask

  int exp_g[5] = '{1, 2, 4, 8, 1};
  int exp_d[5] = '{1, 2, 3, 4, 1};

  initial begin
    reset   = 1'b1;
    req     = 4'b1111;
    data_in = 20'hFFFFF;
    // Reset held with every requester active: nothing may strobe.
    run(20);

    // Single requester, repeated while req is held.
    req     = 4'b0001;
    data_in = '0;
    set_word(0, 5'h15);
    log_cyc.delete();
    reset = 1'b0;
    run(20);
    chk("t2_count", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      chk("t2_cyc0", log_cyc[0], 10);
      chk("t2_cyc1", log_cyc[1], 18);
      chk("t2_grant", log_grant[0], 1);
      chk("t2_data", log_data[0], 32'h15);
    end

    // All requesting: round-robin order.
    restart();
    req = 4'b1111;
    set_word(0, 5'd1);
    set_word(1, 5'd2);
    set_word(2, 5'd3);
    set_word(3, 5'd4);
    run(44);
    chk("t3_count", log_grant.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_grant.size()) begin
        chk("t3_grant", log_grant[i], exp_g[i]);
        chk("t3_data", log_data[i], exp_d[i]);
      end
    end

    // Drop req and change data during SETTLE: the loaded word is still delivered.
    restart();
    req = 4'b0001;
    set_word(0, 5'h0A);
    run(9);
    req = 4'b0000;
    set_word(0, 5'h1F);
    run(4);
    chk("t4_count", log_cyc.size(), 1);
    if (log_cyc.size() == 1) begin
      chk("t4_cyc", log_cyc[0], 10);
      chk("t4_data", log_data[0], 32'h0A);
      chk("t4_grant", log_grant[0], 1);
    end

    // Reset in SETTLE aborts the transfer and restores the pointer.
    restart();
    req = 4'b0001;
    set_word(0, 5'h03);
    run(9);
    reset = 1'b1;
    #1;
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_xdata_async", 32'(x_data), 32'd0);
    run(2);
    chk("t5_abort", log_cyc.size(), 0);
    req = 4'b1010;
    set_word(1, 5'h07);
    set_word(3, 5'h09);
    reset = 1'b0;
    run(12);
    chk("t5_count", log_grant.size(), 1);
    if (log_grant.size() == 1) begin
      chk("t5_grant", log_grant[0], 2);
      chk("t5_data", log_data[0], 32'h07);
      chk("t5_cyc", log_cyc[0], 10);
    end

    // Idle ticks after one transfer: x_data holds, nothing strobes.
    restart();
    req = 4'b0001;
    set_word(0, 5'h11);
    run(8);
    req = 4'b0000;
    run(41);
    chk("t6_count", log_cyc.size(), 1);
    chk("t6_xdata", 32'(x_data), 32'h11);
`ifdef XFER_MISS_CNT_EN
    chk("t6_miss5", 32'(miss_cnt), 32'd5);
    run(300 * DIV);
    chk("t6_miss_sat", 32'(miss_cnt), 32'd255);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
